gate_sweep_ctrl: RTL and testbench

// - Sequencer for exhaustive truth-table checking of a small combinational gate (e.g. the switch-level CMOS OR3).
// - On start, drives every input vector 0..2^N_IN-1 onto the gate and waits SETTLE cycles per vector.
// - Samples the gate output and compares it against the selected reference function.
// - Reports pass/fail, mismatch count and first failing vector; this is the synthesizable replacement for a delay-loop bench.

---
 rtl/gate_sweep_ctrl_if.sv | 39 +++
 rtl/gate_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_ctrl_if.sv
// Bundle between the truth-table sweep sequencer and its environment.
// master: the side that supplies start and the gate output y_in, and observes the results.
// slave : the sequencer itself.
// Signals:
//   start            sweep request
//   y_in             output of the gate under test
//   x_out            vector driven onto the gate inputs
//   busy/done        sweep in progress / one-cycle completion pulse
//   pass, err_cnt    result of the last sweep
//   first_fail_vec   lowest failing vector, qualified by first_fail_valid
//   log_valid/log_vec/log_y  per-vector sample log
interface gate_sweep_ctrl_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic            y_in;
    logic [N_IN-1:0] x_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_fail_vec;
    logic            first_fail_valid;
    logic            log_valid;
    logic [N_IN-1:0] log_vec;
    logic            log_y;

    modport master (
        output start, y_in,
        input  x_out, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid,
               log_valid, log_vec, log_y
    );

    modport slave (
        input  start, y_in,
        output x_out, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid,
               log_valid, log_vec, log_y
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sequencer for a small combinational gate.
// On an accepted start it walks x_out through 0..2^N_IN-1, lets each vector
// settle for SETTLE cycles, samples y_in for one cycle against the reference
// function selected by FUNC, and reports the pass/fail summary.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (all outputs to 0, state IDLE)
//   bus  - gate_sweep_ctrl_if slave: start/y_in in; vector, status, results and log out
module gate_sweep_ctrl #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 5,
    parameter int FUNC   = 0
) (
    input logic            clk,
    input logic            rst,
    gate_sweep_ctrl_if.slave bus
);
    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]   LAST_VEC  = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   x_q, x_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              ffvalid_q, ffvalid_d;
    logic              pass_q, pass_d;
    logic              mismatch;

    // Reduction-style reference for the gate under test.
    function automatic logic ref_y(input logic [N_IN-1:0] x);
        case (FUNC)
            0:       return |x;
            1:       return ~|x;
            2:       return &x;
            3:       return ~&x;
            default: return ^x;
        endcase
    endfunction

    // Case inequality so that an X/Z from the gate model is scored as a miss.
    always_comb begin
        mismatch = (bus.y_in !== ref_y(x_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            wait_q    <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            pass_q    <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        wait_d    = wait_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        pass_d    = pass_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_SETTLE;
                    x_d       = '0;
                    wait_d    = WAIT_INIT;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            S_SETTLE: begin
                if (wait_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + (N_IN+1)'(1);
                    if (!ffvalid_q) begin
                        ffv_d     = x_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if (x_q == LAST_VEC) begin
                    // pass is decided here so it already includes the final compare
                    // when done is shown in the following cycle.
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = S_SETTLE;
                    x_d     = x_q + N_IN'(1);
                    wait_d  = WAIT_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.x_out            = x_q;
        bus.busy             = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
        bus.done             = (state_q == S_DONE);
        bus.pass             = pass_q;
        bus.err_cnt          = err_q;
        bus.first_fail_vec   = ffv_q;
        bus.first_fail_valid = ffvalid_q;
        bus.log_valid        = (state_q == S_SAMPLE);
        bus.log_vec          = (state_q == S_SAMPLE) ? x_q : '0;
        bus.log_y            = (state_q == S_SAMPLE) & bus.y_in;
    end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
module tb_gate_sweep_ctrl;
    localparam int N  = 3;
    localparam int NV = 8;
    localparam int SA = 5;
    localparam int SB = 1;
    localparam int FA = 0;
    localparam int FB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    bit [NV-1:0] mask_a, mask_b;
    int cyc = 0;
    bit mon_en = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    gate_sweep_ctrl_if #(.N_IN(N)) bus_a ();
    gate_sweep_ctrl_if #(.N_IN(N)) bus_b ();

    gate_sweep_ctrl #(.N_IN(N), .SETTLE(SA), .FUNC(FA)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    gate_sweep_ctrl #(.N_IN(N), .SETTLE(SB), .FUNC(FB)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    always @(posedge clk) cyc <= cyc + 1;

    // Reference gate behaviour, defined by counting ones in the vector.
    function automatic bit ref_fn(input int func, input int x);
        int ones = 0;
        for (int i = 0; i < N; i++) ones += (x >> i) & 1;
        case (func)
            0:       return ones > 0;
            1:       return ones == 0;
            2:       return ones == N;
            3:       return ones != N;
            default: return (ones % 2) == 1;
        endcase
    endfunction

    // Gate model: ideal function with per-vector fault flips.
    always_comb bus_a.y_in = ref_fn(FA, int'(bus_a.x_out)) ^ mask_a[bus_a.x_out];
    always_comb bus_b.y_in = ref_fn(FB, int'(bus_b.x_out)) ^ mask_b[bus_b.x_out];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Model state per DUT: sweep start cycle, captured fault mask, held results.
    int t0[2]         = '{-1, -1};
    bit [NV-1:0] sm[2];
    int h_err[2]      = '{0, 0};
    int h_pass[2]     = '{0, 0};
    int h_ffv[2]      = '{0, 0};
    int h_ffval[2]    = '{0, 0};
    int h_x[2]        = '{0, 0};

    task automatic model_step(input int d, input int c);
        int p, last, rel, k, ex_x, e_err, e_ffv;
        bit active, e_busy, e_done, e_log;
        int o_busy, o_done, o_logv, o_logvec, o_logy, o_x, o_err, o_pass, o_ffv, o_ffval;
        bit st, rs;
        bit [NV-1:0] cur_mask;
        string nm;
        nm     = (d == 0) ? "A" : "B";
        p      = ((d == 0) ? SA : SB) + 1;
        last   = NV * p;
        o_busy   = (d == 0) ? int'(bus_a.busy)             : int'(bus_b.busy);
        o_done   = (d == 0) ? int'(bus_a.done)             : int'(bus_b.done);
        o_logv   = (d == 0) ? int'(bus_a.log_valid)        : int'(bus_b.log_valid);
        o_logvec = (d == 0) ? int'(bus_a.log_vec)          : int'(bus_b.log_vec);
        o_logy   = (d == 0) ? int'(bus_a.log_y)            : int'(bus_b.log_y);
        o_x      = (d == 0) ? int'(bus_a.x_out)            : int'(bus_b.x_out);
        o_err    = (d == 0) ? int'(bus_a.err_cnt)          : int'(bus_b.err_cnt);
        o_pass   = (d == 0) ? int'(bus_a.pass)             : int'(bus_b.pass);
        o_ffv    = (d == 0) ? int'(bus_a.first_fail_vec)   : int'(bus_b.first_fail_vec);
        o_ffval  = (d == 0) ? int'(bus_a.first_fail_valid) : int'(bus_b.first_fail_valid);
        st       = (d == 0) ? bus_a.start : bus_b.start;
        rs       = (d == 0) ? rst_a : rst_b;
        cur_mask = (d == 0) ? mask_a : mask_b;

        rel    = c - t0[d];
        active = (t0[d] >= 0) && (rel >= 1) && (rel <= last + 1);
        e_busy = active && (rel <= last);
        e_done = active && (rel == last + 1);
        e_log  = e_busy && (rel % p == 0);

        chk({nm, ".busy"}, o_busy, int'(e_busy));
        chk({nm, ".done"}, o_done, int'(e_done));
        chk({nm, ".log_valid"}, o_logv, int'(e_log));
        if (e_log) begin
            k = rel / p - 1;
            chk({nm, ".log_vec"}, o_logvec, k);
            chk({nm, ".log_y"}, o_logy, int'(ref_fn((d == 0) ? FA : FB, k) ^ sm[d][k]));
        end
        if (e_busy)      ex_x = (rel - 1) / p;
        else if (active) ex_x = NV - 1;
        else             ex_x = h_x[d];
        chk({nm, ".x_out"}, o_x, ex_x);

        if (active && rel == 1) begin
            chk({nm, ".err_cleared"}, o_err, 0);
            chk({nm, ".pass_cleared"}, o_pass, 0);
            chk({nm, ".ffval_cleared"}, o_ffval, 0);
        end
        if (!active) begin
            chk({nm, ".err_hold"}, o_err, h_err[d]);
            chk({nm, ".pass_hold"}, o_pass, h_pass[d]);
            chk({nm, ".ffv_hold"}, o_ffv, h_ffv[d]);
            chk({nm, ".ffval_hold"}, o_ffval, h_ffval[d]);
        end
        if (e_done) begin
            e_err = 0;
            e_ffv = -1;
            for (int v = 0; v < NV; v++) begin
                if (sm[d][v]) begin
                    e_err++;
                    if (e_ffv < 0) e_ffv = v;
                end
            end
            h_err[d]   = e_err;
            h_pass[d]  = (e_err == 0);
            h_ffval[d] = (e_ffv >= 0);
            h_ffv[d]   = (e_ffv >= 0) ? e_ffv : 0;
            h_x[d]     = NV - 1;
            chk({nm, ".err_cnt"}, o_err, h_err[d]);
            chk({nm, ".pass"}, o_pass, h_pass[d]);
            chk({nm, ".ffval"}, o_ffval, h_ffval[d]);
            chk({nm, ".ffv"}, o_ffv, h_ffv[d]);
        end

        if (rs) begin
            t0[d]      = -1;
            h_err[d]   = 0;
            h_pass[d]  = 0;
            h_ffv[d]   = 0;
            h_ffval[d] = 0;
            h_x[d]     = 0;
        end else if (st && !active) begin
            t0[d] = c;
            sm[d] = cur_mask;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            model_step(0, cyc);
            model_step(1, cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single start pulse on A, then wait out the full sweep plus a gap.
    task automatic sweep_a(input bit [NV-1:0] m, input int gap);
        mask_a = m;
        bus_a.start = 1'b1;
        step(1);
        bus_a.start = 1'b0;
        step(NV * (SA + 1) + gap);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        mask_a = '0;
        mask_b = '0;
        step(2);
        mon_en = 1'b1;
        step(2);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step(2);
        fork
            begin : thread_a
                sweep_a(8'h00, 4);          // ideal OR3
                sweep_a(8'hFE, 4);          // y tied low
                sweep_a(8'h54, 4);          // y follows x[0]
                // start re-pulsed during the sweep and in the done cycle
                bus_a.start = 1'b1; step(1); bus_a.start = 1'b0;
                step(9);  bus_a.start = 1'b1; step(1); bus_a.start = 1'b0;
                step(38); bus_a.start = 1'b1; step(1); bus_a.start = 1'b0;
                step(5);
                // reset mid-sweep, then a fresh sweep
                bus_a.start = 1'b1; step(1); bus_a.start = 1'b0;
                step(19); rst_a = 1'b1; step(1); rst_a = 1'b0;
                step(4);
                sweep_a(8'h00, 4);
                for (int i = 0; i < 10; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        mask_a = 8'($urandom);
                        bus_a.start = 1'b1; step(1); bus_a.start = 1'b0;
                        step($urandom_range(1, 50));
                        rst_a = 1'b1; step(1); rst_a = 1'b0;
                        step($urandom_range(0, 3));
                    end else begin
                        sweep_a(8'($urandom), $urandom_range(1, 6));
                    end
                end
            end
            begin : thread_b
                // start held high: back-to-back sweeps
                mask_b = '0;
                bus_b.start = 1'b1;
                step(40);
                bus_b.start = 1'b0;
                step(20);
                for (int i = 0; i < 12; i++) begin
                    mask_b = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                    bus_b.start = 1'b1;
                    step($urandom_range(1, 40));
                    bus_b.start = 1'b0;
                    step(20);
                end
            end
        join
        step(2);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
